fwd_hazard_unit: RTL and testbench

- Parametrised successor to the combinational EX-stage forwarding logic.
- Keeps a registered scoreboard of in-flight destination registers across DEPTH post-EX stages, and tracks how many cycles remain until each multi-cycle (load) result is ready.
- Drives per-source forward selects for any number of operands, and raises a load-use stall when the youngest producer's data is not yet ready.
- Sits beside the EX stage and feeds the operand muxes and the ID/EX hold logic.

---
 rtl/fwd_pkg.sv | 17 +
 rtl/fwd_hazard_unit_match.sv | 25 ++
 rtl/fwd_hazard_unit.sv | 68 ++++++
 tb/tb_fwd_hazard_unit.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/fwd_pkg.sv
// fwd_pkg: shared encodings and scoreboard entry type for the forwarding unit
package fwd_pkg;
  localparam int REG_W_MAX = 8;
  localparam int RDY_W_MAX = 4;
  localparam int SEL_W_MAX = 4;
  typedef logic [SEL_W_MAX-1:0] fwd_sel_t;
  localparam fwd_sel_t FWD_RF = '0;
  typedef struct packed {
    logic                 vld;
    logic                 wr;
    logic [REG_W_MAX-1:0] rd;
    logic [RDY_W_MAX-1:0] rdy_cnt;
  } sb_entry_t;
  function automatic logic [RDY_W_MAX-1:0] dec_sat(input logic [RDY_W_MAX-1:0] c);
    return (c == '0) ? c : c - 1'b1;
  endfunction
endpackage

// File: rtl/fwd_hazard_unit_match.sv
// fwd_src_match: youngest-producer priority matcher for one source operand
module fwd_src_match
  import fwd_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int REG_W = 5,
  parameter int SEL_W = 2
)(
  input  sb_entry_t [DEPTH-1:0] ent,
  input  logic [REG_W-1:0]      src,
  input  logic                  used,
  output logic [SEL_W-1:0]      sel,
  output logic                  not_ready
);
  always_comb begin
    sel = SEL_W'(FWD_RF);
    not_ready = 1'b0;
    for (int k = DEPTH; k >= 1; k--) begin
      if (ent[k-1].vld && ent[k-1].wr && ent[k-1].rd == REG_W_MAX'(src) && src != '0 && used) begin
        sel = SEL_W'(k);
        not_ready = ent[k-1].rdy_cnt != '0;
      end
    end
  end
endmodule

// File: rtl/fwd_hazard_unit.sv
// fwd_hazard_unit: scoreboard-based operand forwarding and load-use stall
module fwd_hazard_unit
  import fwd_pkg::*;
#(
  parameter int DEPTH    = 2,
  parameter int NUM_SRC  = 2,
  parameter int REG_W    = 5,
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 16,
  localparam int SEL_W   = $clog2(DEPTH+1)
)(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     ex_valid,
  input  logic [REG_W-1:0]         ex_rd,
  input  logic                     ex_reg_write,
  input  logic                     ex_is_load,
  input  logic [NUM_SRC*REG_W-1:0] ex_src,
  input  logic [NUM_SRC-1:0]       ex_src_used,
  input  logic                     hold,
  input  logic                     flush,
  output logic [NUM_SRC*SEL_W-1:0] fwd_sel,
  output logic                     stall,
  output logic [CNT_W-1:0]         stall_cnt
);
  sb_entry_t [DEPTH-1:0] sb_q, sb_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [NUM_SRC-1:0] not_ready;
  genvar i;
  generate
    for (i = 0; i < NUM_SRC; i++) begin : g_src
      fwd_src_match #(.DEPTH(DEPTH), .REG_W(REG_W), .SEL_W(SEL_W)) u_match (
        .ent       (sb_q),
        .src       (ex_src[i*REG_W +: REG_W]),
        .used      (ex_src_used[i]),
        .sel       (fwd_sel[i*SEL_W +: SEL_W]),
        .not_ready (not_ready[i])
      );
    end
  endgenerate
  assign stall = ex_valid && !hold && !flush && (|not_ready);
  assign stall_cnt = stall_cnt_q;
  always_comb begin
    sb_d = sb_q;
    stall_cnt_d = (stall && !(&stall_cnt_q)) ? stall_cnt_q + 1'b1 : stall_cnt_q;
    if (flush) begin
      sb_d = '0;
    end else if (!hold) begin
      for (int k = DEPTH-1; k >= 1; k--) begin
        sb_d[k] = sb_q[k-1];
        sb_d[k].rdy_cnt = dec_sat(sb_q[k-1].rdy_cnt);
      end
      sb_d[0].vld = ex_valid && !stall;
      sb_d[0].wr = ex_reg_write;
      sb_d[0].rd = REG_W_MAX'(ex_rd);
      sb_d[0].rdy_cnt = ex_is_load ? RDY_W_MAX'(LOAD_LAT) : '0;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sb_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      sb_q <= sb_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end
endmodule

// File: tb/tb_fwd_hazard_unit.sv
// tb_fwd_hazard_unit: directed vector bench for fwd_hazard_unit in three configurations
module tb_fwd_hazard_unit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  int checks = 0;
  int errors = 0;
  logic a_valid, a_wr, a_ld, a_hold, a_flush, a_stall;
  logic [4:0] a_rd;
  logic [9:0] a_src;
  logic [1:0] a_used;
  logic [3:0] a_sel;
  logic [15:0] a_cnt;
  logic b_valid, b_wr, b_ld, b_stall;
  logic [4:0] b_rd;
  logic [14:0] b_src;
  logic [2:0] b_used;
  logic [8:0] b_sel;
  logic [1:0] b_cnt;
  logic c_valid, c_wr, c_ld, c_stall;
  logic [4:0] c_rd;
  logic [9:0] c_src;
  logic [1:0] c_used;
  logic [3:0] c_sel;
  logic [15:0] c_cnt;
  fwd_hazard_unit u_a (
    .clk(clk), .rst_n(rst_n), .ex_valid(a_valid), .ex_rd(a_rd), .ex_reg_write(a_wr),
    .ex_is_load(a_ld), .ex_src(a_src), .ex_src_used(a_used), .hold(a_hold), .flush(a_flush),
    .fwd_sel(a_sel), .stall(a_stall), .stall_cnt(a_cnt)
  );
  fwd_hazard_unit #(.DEPTH(4), .NUM_SRC(3), .LOAD_LAT(2), .CNT_W(2)) u_b (
    .clk(clk), .rst_n(rst_n), .ex_valid(b_valid), .ex_rd(b_rd), .ex_reg_write(b_wr),
    .ex_is_load(b_ld), .ex_src(b_src), .ex_src_used(b_used), .hold(1'b0), .flush(1'b0),
    .fwd_sel(b_sel), .stall(b_stall), .stall_cnt(b_cnt)
  );
  fwd_hazard_unit #(.LOAD_LAT(0)) u_c (
    .clk(clk), .rst_n(rst_n), .ex_valid(c_valid), .ex_rd(c_rd), .ex_reg_write(c_wr),
    .ex_is_load(c_ld), .ex_src(c_src), .ex_src_used(c_used), .hold(1'b0), .flush(1'b0),
    .fwd_sel(c_sel), .stall(c_stall), .stall_cnt(c_cnt)
  );
  typedef struct {
    logic v, w, ld, h, f;
    logic [4:0] rd, s0, s1;
    logic [1:0] u, e0, e1;
    logic es;
    logic [15:0] ec;
  } vec_t;
  localparam int NV = 25;
  vec_t vec [NV];
  function automatic vec_t mk(input logic v, w, ld, h, f, input int rd, s0, s1, u, e0, e1, input logic es, input int ec);
    vec_t r;
    r.v = v; r.w = w; r.ld = ld; r.h = h; r.f = f;
    r.rd = 5'(rd); r.s0 = 5'(s0); r.s1 = 5'(s1); r.u = 2'(u);
    r.e0 = 2'(e0); r.e1 = 2'(e1); r.es = es; r.ec = 16'(ec);
    return r;
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic bvec(input int n, input logic v, w, ld, input logic [4:0] rd, s0, s1, s2, input logic [2:0] u,
                      input logic [2:0] e0, e1, e2, input logic es, input logic [1:0] ec);
    @(negedge clk);
    b_valid = v; b_wr = w; b_ld = ld; b_rd = rd; b_src = {s2, s1, s0}; b_used = u;
    #1;
    chk($sformatf("b%0d_sel0", n), 32'(b_sel[2:0]), 32'(e0));
    chk($sformatf("b%0d_sel1", n), 32'(b_sel[5:3]), 32'(e1));
    chk($sformatf("b%0d_sel2", n), 32'(b_sel[8:6]), 32'(e2));
    chk($sformatf("b%0d_stall", n), 32'(b_stall), 32'(es));
    chk($sformatf("b%0d_cnt", n), 32'(b_cnt), 32'(ec));
  endtask
  initial begin
    vec[0]  = mk(1,1,0,0,0,  5, 5'd1, 5'd2, 3, 0,0,0,0);
    vec[1]  = mk(1,1,0,0,0,  6, 5,  0, 3, 1,0,0,0);
    vec[2]  = mk(1,0,0,0,0,  9, 5,  6, 3, 2,1,0,0);
    vec[3]  = mk(1,1,0,0,0,  3, 9,  6, 3, 0,2,0,0);
    vec[4]  = mk(1,1,0,0,0,  3, 3,  3, 3, 1,1,0,0);
    vec[5]  = mk(1,1,0,0,0,  4, 3,  3, 1, 1,0,0,0);
    vec[6]  = mk(1,1,1,0,0,  7, 0,  0, 0, 0,0,0,0);
    vec[7]  = mk(1,1,0,0,0,  8, 7,  4, 3, 1,2,1,0);
    vec[8]  = mk(1,1,0,0,0,  8, 7,  4, 3, 2,0,0,1);
    vec[9]  = mk(1,1,1,0,0,  7, 8,  0, 3, 1,0,0,1);
    vec[10] = mk(1,1,1,0,0, 10, 0,  0, 0, 0,0,0,1);
    vec[11] = mk(1,1,0,0,0, 11, 7, 10, 3, 2,1,1,1);
    vec[12] = mk(1,1,0,0,0, 11, 7, 10, 3, 0,2,0,2);
    vec[13] = mk(1,1,1,0,0, 12, 0,  0, 0, 0,0,0,2);
    vec[14] = mk(1,1,0,1,0, 13,12,  0, 1, 1,0,0,2);
    vec[15] = mk(1,1,0,1,0, 13,12,  0, 1, 1,0,0,2);
    vec[16] = mk(1,1,0,1,0, 13,12,  0, 1, 1,0,0,2);
    vec[17] = mk(1,1,0,0,0, 13,12,  0, 1, 1,0,1,2);
    vec[18] = mk(1,1,0,0,0, 13,12,  0, 1, 2,0,0,3);
    vec[19] = mk(1,1,1,0,0, 14, 0,  0, 0, 0,0,0,3);
    vec[20] = mk(1,1,0,0,1, 15,14, 13, 3, 1,2,0,3);
    vec[21] = mk(1,1,0,0,0, 15,14, 13, 3, 0,0,0,3);
    vec[22] = mk(1,1,1,0,0, 16, 0,  0, 0, 0,0,0,3);
    vec[23] = mk(0,1,0,0,0,  0,16,  0, 1, 1,0,0,3);
    vec[24] = mk(1,0,0,0,0,  0,16,  0, 1, 2,0,0,3);
    {a_valid, a_wr, a_ld, a_hold, a_flush, a_rd, a_src, a_used} = '0;
    {b_valid, b_wr, b_ld, b_rd, b_src, b_used} = '0;
    {c_valid, c_wr, c_ld, c_rd, c_src, c_used} = '0;
    @(negedge clk);
    @(negedge clk);
    chk("reset_sel", 32'(a_sel), 32'd0);
    chk("reset_stall", 32'(a_stall), 32'd0);
    chk("reset_cnt", 32'(a_cnt), 32'd0);
    rst_n = 1'b1;
    for (int n = 0; n < NV; n++) begin
      @(negedge clk);
      a_valid = vec[n].v; a_wr = vec[n].w; a_ld = vec[n].ld; a_hold = vec[n].h; a_flush = vec[n].f;
      a_rd = vec[n].rd; a_src = {vec[n].s1, vec[n].s0}; a_used = vec[n].u;
      #1;
      chk($sformatf("v%0d_sel0", n), 32'(a_sel[1:0]), 32'(vec[n].e0));
      chk($sformatf("v%0d_sel1", n), 32'(a_sel[3:2]), 32'(vec[n].e1));
      chk($sformatf("v%0d_stall", n), 32'(a_stall), 32'(vec[n].es));
      chk($sformatf("v%0d_cnt", n), 32'(a_cnt), 32'(vec[n].ec));
    end
    @(negedge clk);
    c_valid = 1'b1; c_wr = 1'b1; c_ld = 1'b1; c_rd = 5'd7;
    #1;
    chk("lat0_load_stall", 32'(c_stall), 32'd0);
    @(negedge clk);
    c_ld = 1'b0; c_rd = 5'd8; c_src = {5'd0, 5'd7}; c_used = 2'b01;
    #1;
    chk("lat0_use_sel0", 32'(c_sel[1:0]), 32'd1);
    chk("lat0_use_stall", 32'(c_stall), 32'd0);
    c_valid = 1'b0;
    @(negedge clk);
    a_valid = 1'b1; a_wr = 1'b1; a_ld = 1'b1; a_rd = 5'd20; a_used = 2'b00; a_hold = 1'b0; a_flush = 1'b0;
    @(negedge clk);
    a_ld = 1'b0; a_rd = 5'd21; a_src = {5'd0, 5'd20}; a_used = 2'b01;
    #1;
    chk("pre_rst_stall", 32'(a_stall), 32'd1);
    chk("pre_rst_sel0", 32'(a_sel[1:0]), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_stall", 32'(a_stall), 32'd0);
    chk("rst_sel", 32'(a_sel), 32'd0);
    chk("rst_cnt", 32'(a_cnt), 32'd0);
    #1 rst_n = 1'b1;
    a_valid = 1'b0;
    bvec(0, 1,1,1,  7,  0, 0, 0, 3'b000, 0,0,0, 0, 0);
    bvec(1, 1,1,0,  8,  7, 0, 7, 3'b001, 1,0,0, 1, 0);
    bvec(2, 1,1,0,  8,  7, 0, 7, 3'b001, 2,0,0, 1, 1);
    bvec(3, 1,1,0,  8,  7, 0, 7, 3'b001, 3,0,0, 0, 2);
    bvec(4, 1,1,0,  9,  7, 8, 0, 3'b111, 4,1,0, 0, 2);
    bvec(5, 1,1,0, 11,  9, 8, 9, 3'b011, 1,2,0, 0, 2);
    bvec(6, 1,1,1, 10,  0, 0, 0, 3'b000, 0,0,0, 0, 2);
    bvec(7, 1,1,0, 12, 10, 0, 0, 3'b001, 1,0,0, 1, 2);
    bvec(8, 1,1,0, 12, 10, 0, 0, 3'b001, 2,0,0, 1, 3);
    bvec(9, 1,1,0, 12, 10, 0, 0, 3'b001, 3,0,0, 0, 3);
    @(negedge clk);
    b_valid = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
